// File: rtl/muldiv_pkg.sv
// Shared FSM state type, RV32M funct3 encodings and operand-signedness decode
// for the EX-stage multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic a_signed(input logic [2:0] f3);
    return (f3 == MD_MULH) || (f3 == MD_MULHSU) || (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] f3);
    return (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_sequencer_if.sv
// Issue/stall/result bundle between the EX stage and the mul/div sequencer.
interface ex_muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            flush_i;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, funct3_i, op_a_i, op_b_i, flush_i,
    input  stall_o, done_o, result_o
  );

  modport slave (
    input  start_i, funct3_i, op_a_i, op_b_i, flush_i,
    output stall_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide on
// operand magnitudes, one step per enabled cycle, with the step counter.
module muldiv_core #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            init,
  input  logic            step_en,
  input  logic            div_mode,
  input  logic [XLEN-1:0] init_a,
  input  logic [XLEN-1:0] init_b,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] sr_nxt,
  output logic            last
);
  // acc: product high half / partial remainder; sr: multiplier / quotient
  logic [XLEN-1:0]  acc;
  logic [XLEN-1:0]  sr;
  logic [XLEN-1:0]  opb;
  logic [CNT_W-1:0] cnt;
  logic [XLEN:0]    sum;
  logic [XLEN:0]    partial;
  logic [XLEN:0]    shifted;
  logic             ge;

  always_comb begin
    sum     = {1'b0, acc} + {1'b0, opb};
    partial = sr[0] ? sum : {1'b0, acc};
    shifted = {acc, sr[XLEN-1]};
    ge      = shifted >= {1'b0, opb};
    if (div_mode) begin
      acc_nxt = ge ? XLEN'(shifted - {1'b0, opb}) : shifted[XLEN-1:0];
      sr_nxt  = {sr[XLEN-2:0], ge};
    end else begin
      acc_nxt = partial[XLEN:1];
      sr_nxt  = {partial[0], sr[XLEN-1:1]};
    end
  end

  assign last = (cnt == CNT_W'(XLEN - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc <= '0;
      sr  <= '0;
      opb <= '0;
      cnt <= '0;
    end else if (init) begin
      acc <= '0;
      sr  <= init_a;
      opb <= init_b;
      cnt <= '0;
    end else if (step_en) begin
      acc <= acc_nxt;
      sr  <= sr_nxt;
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/ex_muldiv_sequencer.sv
// RV32M multiply/divide sequencer: accepts an op from EX, stalls the pipe while
// the iterative core runs, then presents a sign-corrected result for one cycle.
module ex_muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic                   clk,
  input logic                   reset,
  ex_muldiv_sequencer_if.slave  md
);
  localparam int CNT_W = $clog2(XLEN);

  state_t          state;
  state_t          state_nxt;
  logic [2:0]      f3_q;
  logic            sa_q;
  logic            sb_q;
  logic [XLEN-1:0] result_q;

  logic            accept;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic            init;
  logic            step_en;
  logic            load_res;
  logic [XLEN-1:0] acc_nxt;
  logic [XLEN-1:0] sr_nxt;
  logic            last;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quot_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] final_res;

  assign accept = md.start_i && !md.flush_i;
  assign sa     = a_signed(md.funct3_i) && md.op_a_i[XLEN-1];
  assign sb     = b_signed(md.funct3_i) && md.op_b_i[XLEN-1];
  assign mag_a  = sa ? -md.op_a_i : md.op_a_i;
  assign mag_b  = sb ? -md.op_b_i : md.op_b_i;

  // Divide-by-zero and INT_MIN / -1 bypass the core entirely
  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (is_div(md.funct3_i)) begin
      if (md.op_b_i == '0) begin
        special     = 1'b1;
        special_res = md.funct3_i[1] ? md.op_a_i : '1;
      end else if (b_signed(md.funct3_i) && md.op_a_i == {1'b1, {(XLEN-1){1'b0}}}
                   && md.op_b_i == '1) begin
        special     = 1'b1;
        special_res = md.funct3_i[1] ? '0 : md.op_a_i;
      end
    end
  end

  assign prod      = {acc_nxt, sr_nxt};
  assign prod_fix  = (sa_q ^ sb_q) ? -prod : prod;
  assign quot_fix  = (sa_q ^ sb_q) ? -sr_nxt : sr_nxt;
  assign rem_fix   = sa_q ? -acc_nxt : acc_nxt;

  always_comb begin
    if (is_div(f3_q))
      final_res = (f3_q == MD_REM || f3_q == MD_REMU) ? rem_fix : quot_fix;
    else
      final_res = (f3_q == MD_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_nxt = state;
    init      = 1'b0;
    step_en   = 1'b0;
    load_res  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          init      = 1'b1;
          state_nxt = special ? DONE : BUSY;
          load_res  = special;
        end
      end
      BUSY: begin
        step_en = 1'b1;
        if (last) begin
          state_nxt = DONE;
          load_res  = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (md.flush_i) begin
      state_nxt = IDLE;
      load_res  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      f3_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      if (init) begin
        f3_q <= md.funct3_i;
        sa_q <= sa;
        sb_q <= sb;
      end
      if (load_res)
        result_q <= (state == IDLE) ? special_res : final_res;
    end
  end

  assign md.stall_o  = (state == IDLE && accept) || (state == BUSY);
  assign md.done_o   = (state == DONE);
  assign md.result_o = result_q;

  muldiv_core #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .init     (init),
    .step_en  (step_en),
    .div_mode (is_div(f3_q)),
    .init_a   (mag_a),
    .init_b   (mag_b),
    .acc_nxt  (acc_nxt),
    .sr_nxt   (sr_nxt),
    .last     (last)
  );
endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Self-checking bench for ex_muldiv_sequencer: directed vector table, flush/reset/
// restart sequences, and random ops against a plain-arithmetic RV32M model.
module tb_ex_muldiv_sequencer;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_muldiv_sequencer_if #(.XLEN(32)) md();

  ex_muldiv_sequencer #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      MD_MUL:    begin p = sa * sb; return p[31:0];  end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub; return p[63:32]; end
      MD_MULHU:  begin p = ua * ub; return p[63:32]; end
      MD_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit special_op(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return f3[2] && (b == 0 || ((f3 == MD_DIV || f3 == MD_REM) &&
                                a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Called just after a falling edge with the sequencer idle; returns just after
  // the falling edge of the cycle following done_o.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name,
                        input bit toggle);
    int n;
    bit seen;
    bit stall_ok;
    md.start_i  = 1'b1;
    md.funct3_i = f3;
    md.op_a_i   = a;
    md.op_b_i   = b;
    md.flush_i  = 1'b0;
    #1 check({name, " stall at issue"}, 32'(md.stall_o), 32'd1);
    @(negedge clk);
    md.start_i  = 1'b0;
    md.op_a_i   = $urandom;
    md.op_b_i   = $urandom;
    md.funct3_i = 3'($urandom);
    n = 1;
    seen = 1'b0;
    stall_ok = 1'b1;
    while (n <= 40) begin
      if (md.done_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (md.stall_o !== 1'b1) stall_ok = 1'b0;
      if (toggle) md.start_i = 1'($urandom);
      @(negedge clk);
      n++;
    end
    md.start_i = 1'b0;
    check({name, " done seen"}, 32'(seen), 32'd1);
    check({name, " latency"}, 32'(n), 32'(lat));
    check({name, " result"}, md.result_o, exp);
    check({name, " stall in done"}, 32'(md.stall_o), 32'd0);
    check({name, " stall while busy"}, 32'(stall_ok), 32'd1);
    @(negedge clk);
    check({name, " done pulse width"}, 32'(md.done_o), 32'd0);
    check({name, " result held"}, md.result_o, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    logic [2:0]  f3;
    logic [31:0] a, b;

    vecs[0]  = '{MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "MUL 7*-3"};
    vecs[1]  = '{MD_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, "MULH min*min"};
    vecs[2]  = '{MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "MULHU max*max"};
    vecs[3]  = '{MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "MULHSU -1*max"};
    vecs[4]  = '{MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, "DIV -7/2"};
    vecs[5]  = '{MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, "REM -7/2"};
    vecs[6]  = '{MD_DIVU,   32'd100,        32'd7,         32'd14,        33, "DIVU 100/7"};
    vecs[7]  = '{MD_REMU,   32'd100,        32'd7,         32'd2,         33, "REMU 100/7"};
    vecs[8]  = '{MD_DIV,    32'h1234_5678,  32'd0,         32'hFFFF_FFFF, 1,  "DIV x/0"};
    vecs[9]  = '{MD_REM,    32'h1234_5678,  32'd0,         32'h1234_5678, 1,  "REM x/0"};
    vecs[10] = '{MD_DIVU,   32'h1234_5678,  32'd0,         32'hFFFF_FFFF, 1,  "DIVU x/0"};
    vecs[11] = '{MD_REMU,   32'h1234_5678,  32'd0,         32'h1234_5678, 1,  "REMU x/0"};
    vecs[12] = '{MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  "DIV ovf"};
    vecs[13] = '{MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  "REM ovf"};
    vecs[14] = '{MD_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33, "DIVU min/max"};

    md.start_i  = 1'b0;
    md.funct3_i = MD_MUL;
    md.op_a_i   = '0;
    md.op_b_i   = '0;
    md.flush_i  = 1'b0;
    reset       = 1'b0;
    repeat (3) @(negedge clk);
    check("reset done", 32'(md.done_o), 32'd0);
    check("reset result", md.result_o, 32'd0);
    check("reset stall", 32'(md.stall_o), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post-reset done", 32'(md.done_o), 32'd0);

    for (int i = 0; i < 15; i++)
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name, 1'b0);

    // Flush in the tenth BUSY cycle, then issue a fresh op on the very next cycle
    md.start_i  = 1'b1;
    md.funct3_i = MD_MUL;
    md.op_a_i   = 32'd5;
    md.op_b_i   = 32'd6;
    @(negedge clk);
    md.start_i = 1'b0;
    repeat (9) @(negedge clk);
    md.flush_i = 1'b1;
    #1 check("flush stall same cycle", 32'(md.stall_o), 32'd1);
    @(negedge clk);
    md.flush_i = 1'b0;
    check("flush stall next", 32'(md.stall_o), 32'd0);
    check("flush no done", 32'(md.done_o), 32'd0);
    run_op(MD_MUL, 32'd9, 32'd11, 32'd99, 33, "post-flush MUL", 1'b0);

    // start_i toggling while busy must not restart or disturb the op
    run_op(MD_DIVU, 32'd1000, 32'd3, 32'd333, 33, "toggle start", 1'b1);

    // Reset mid-BUSY aborts with no done and clears the result
    md.start_i  = 1'b1;
    md.funct3_i = MD_DIVU;
    md.op_a_i   = 32'd77;
    md.op_b_i   = 32'd5;
    @(negedge clk);
    md.start_i = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid-busy reset done", 32'(md.done_o), 32'd0);
    check("mid-busy reset result", md.result_o, 32'd0);
    check("mid-busy reset stall", 32'(md.stall_o), 32'd0);
    reset = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (md.done_o === 1'b1) dones++;
    end
    check("no done after abort", 32'(dones), 32'd0);

    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      run_op(f3, a, b, model(f3, a, b), special_op(f3, a, b) ? 1 : 33,
             $sformatf("rand%0d f3=%0d a=%h b=%h", i, f3, a, b), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
